// File: rtl/aes_sched_pkg.sv
// aes_sched_pkg: shared widths, key-size codes and FSM states for the AES scheduler
package aes_sched_pkg;
  localparam int AES_KEY_W = 256;
  localparam int AES_BLK_W = 128;
  localparam logic [1:0] AES_SZ_128 = 2'b00;
  localparam logic [1:0] AES_SZ_192 = 2'b01;
  localparam logic [1:0] AES_SZ_256 = 2'b10;
  localparam logic [1:0] AES_SZ_RSVD = 2'b11;
  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_DONE, ST_RESP} state_e;
endpackage

// File: rtl/aes_rr_pick.sv
// aes_rr_pick: rotate-priority picker, first set valid bit at or after ptr (mod N)
module aes_rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);
  always_comb begin
    logic [IW:0] s;
    s = '0;
    found_o = 1'b0;
    idx_o = '0;
    // scan from the farthest offset down so the nearest hit wins
    for (int k = N - 1; k >= 0; k--) begin
      s = {1'b0, ptr_i} + (IW+1)'(k);
      s = (s >= (IW+1)'(N)) ? s - (IW+1)'(N) : s;
      if (valid_i[s[IW-1:0]]) begin
        found_o = 1'b1;
        idx_o = s[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/aes_sched.sv
// aes_sched: round-robin sharing of one AES engine; AES_SCHED_TIMEOUT_EN adds a completion watchdog
module aes_sched
  import aes_sched_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*AES_KEY_W-1:0]   req_key_i,
  input  logic [NUM_REQ*AES_BLK_W-1:0]   req_data_i,
  input  logic [NUM_REQ*2-1:0]           req_size_i,
  input  logic [NUM_REQ-1:0]             req_dec_i,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  input  logic [NUM_REQ-1:0]             rsp_ready_i,
  output logic [AES_BLK_W-1:0]           rsp_data_o,
  output logic                           rsp_err_o,
  output logic                           eng_load_o,
  output logic [AES_KEY_W-1:0]           eng_key_o,
  output logic [AES_BLK_W-1:0]           eng_data_o,
  output logic [1:0]                     eng_size_o,
  output logic                           eng_dec_o,
  input  logic [AES_BLK_W-1:0]           eng_data_i,
  input  logic                           eng_busy_i,
  output logic                           busy_o,
  output logic [15:0]                    op_cnt_o
);
  localparam int IW = $clog2(NUM_REQ);

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d, gnt_q, gnt_d, cand;
  logic [AES_KEY_W-1:0] key_q, key_d;
  logic [AES_BLK_W-1:0] data_q, data_d, rsp_data_q, rsp_data_d;
  logic [1:0]           size_q, size_d;
  logic                 dec_q, dec_d, rsp_err_q, rsp_err_d, load_q, load_d, busy_q, busy_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [15:0]          op_cnt_q, op_cnt_d;
  logic                 found, tmo;

  aes_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .valid_i(req_valid_i),
    .ptr_i  (ptr_q),
    .found_o(found),
    .idx_o  (cand)
  );

  assign req_ready_o = (state_q == ST_IDLE && found) ? NUM_REQ'(1) << cand : '0;

`ifdef AES_SCHED_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  // counts cycles elapsed since the load pulse; fires on the edge that reaches the limit
  assign tmo_d = (state_q == ST_IDLE) ? '0 : tmo_q + 16'd1;
  assign tmo = tmo_d == 16'(TIMEOUT_CYC);
  always_ff @(posedge clk) begin
    if (!rst_n) tmo_q <= '0;
    else tmo_q <= tmo_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    key_d = key_q;
    data_d = data_q;
    size_d = size_q;
    dec_d = dec_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d = rsp_err_q;
    op_cnt_d = op_cnt_q;
    unique case (state_q)
      ST_IDLE: if (found) begin
        gnt_d = cand;
        key_d = req_key_i[cand*AES_KEY_W +: AES_KEY_W];
        data_d = req_data_i[cand*AES_BLK_W +: AES_BLK_W];
        size_d = req_size_i[cand*2 +: 2];
        dec_d = req_dec_i[cand];
        state_d = (size_d == AES_SZ_RSVD) ? ST_RESP : ST_ISSUE;
        rsp_data_d = (size_d == AES_SZ_RSVD) ? '0 : rsp_data_q;
        rsp_err_d = (size_d == AES_SZ_RSVD) ? 1'b1 : rsp_err_q;
      end
      ST_ISSUE: state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        state_d = eng_busy_i ? ST_WAIT_DONE : tmo ? ST_RESP : ST_WAIT_BUSY;
        rsp_data_d = (!eng_busy_i && tmo) ? '0 : rsp_data_q;
        rsp_err_d = (!eng_busy_i && tmo) ? 1'b1 : rsp_err_q;
      end
      ST_WAIT_DONE: begin
        state_d = (!eng_busy_i || tmo) ? ST_RESP : ST_WAIT_DONE;
        rsp_data_d = !eng_busy_i ? eng_data_i : tmo ? '0 : rsp_data_q;
        rsp_err_d = !eng_busy_i ? 1'b0 : tmo ? 1'b1 : rsp_err_q;
      end
      ST_RESP: if (rsp_ready_i[gnt_q]) begin
        state_d = ST_IDLE;
        ptr_d = (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
        op_cnt_d = op_cnt_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    load_d = state_d == ST_ISSUE;
    busy_d = state_d != ST_IDLE;
    rsp_valid_d = (state_d == ST_RESP) ? NUM_REQ'(1) << gnt_d : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q <= '0;
      gnt_q <= '0;
      key_q <= '0;
      data_q <= '0;
      size_q <= '0;
      dec_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
      load_q <= 1'b0;
      busy_q <= 1'b0;
      rsp_valid_q <= '0;
      op_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      key_q <= key_d;
      data_q <= data_d;
      size_q <= size_d;
      dec_q <= dec_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
      load_q <= load_d;
      busy_q <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      op_cnt_q <= op_cnt_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o = rsp_data_q;
  assign rsp_err_o = rsp_err_q;
  assign eng_load_o = load_q;
  assign eng_key_o = key_q;
  assign eng_data_o = data_q;
  assign eng_size_o = size_q;
  assign eng_dec_o = dec_q;
  assign busy_o = busy_q;
  assign op_cnt_o = op_cnt_q;
endmodule

// File: tb/tb_aes_sched.sv
// tb_aes_sched: scoreboard bench for aes_sched with a latency-configurable engine model; timeout case under AES_SCHED_TIMEOUT_EN
module tb_aes_sched;
  import aes_sched_pkg::*;
  localparam int N = 2;
  localparam int TMO = 16;
  localparam logic [255:0] K0 = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_dec = '0, rsp_ready = '1;
  logic [N-1:0] req_ready, rsp_valid;
  logic [N*256-1:0] req_key = '0;
  logic [N*128-1:0] req_data = '0;
  logic [N*2-1:0] req_size = '0;
  logic [127:0] rsp_data, eng_data, eng_res = '0;
  logic [255:0] eng_key;
  logic [1:0] eng_size;
  logic rsp_err, eng_load, eng_dec, busy, eng_mute = 1'b0;
  logic [15:0] op_cnt;
  int eng_cnt = 0, eng_lat = 10;

  typedef struct { int gnt; logic [127:0] data; logic err; } exp_t;
  exp_t sb[$];
  int gnt_log[$];
  int n_chk = 0, n_fail = 0, cyc = 0, exp_ptr = 0, exp_ops = 0, n_rsp = 0, n_load = 0;
  int t_hs = 0, t_load = 0, t_rsp = 0;
  bit rsp_seen = 0;

  always #5 clk = ~clk;

  aes_sched #(.NUM_REQ(N), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_key_i(req_key), .req_data_i(req_data), .req_size_i(req_size), .req_dec_i(req_dec),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .eng_load_o(eng_load), .eng_key_o(eng_key), .eng_data_o(eng_data), .eng_size_o(eng_size),
    .eng_dec_o(eng_dec), .eng_data_i(eng_res), .eng_busy_i(eng_cnt > 0),
    .busy_o(busy), .op_cnt_o(op_cnt)
  );

  function automatic logic [127:0] eng_fn(logic [255:0] k, logic [127:0] d, logic [1:0] s, logic dc);
    if (k == K0 && d == PT && s == AES_SZ_128 && !dc) return CT;
    return d ^ k[127:0] ^ k[255:128] ^ {dc, 125'd0, s};
  endfunction

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // engine model: busy from the cycle after load for eng_lat cycles, result captured at load
  always @(posedge clk) begin
    if (!rst_n) eng_cnt <= 0;
    else if (eng_load && !eng_mute) begin
      eng_cnt <= eng_lat;
      eng_res <= eng_fn(eng_key, eng_data, eng_size, eng_dec);
    end else if (eng_cnt > 0) eng_cnt <= eng_cnt - 1;
  end

  always @(negedge clk) begin
    exp_t e;
    int idx, pick;
    logic [1:0] s;
    if (rst_n) begin
      if (eng_load) begin n_load++; t_load = cyc; end
      if (|rsp_valid && !rsp_seen) begin rsp_seen = 1; t_rsp = cyc; end
      if (|(req_valid & req_ready)) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
        pick = -1;
        for (int k = N - 1; k >= 0; k--) if (req_valid[(exp_ptr + k) % N]) pick = (exp_ptr + k) % N;
        chk("req_ready_onehot", 128'($countones(req_ready)), 1);
        chk("grant", idx, pick);
        t_hs = cyc;
        gnt_log.push_back(idx);
        s = req_size[idx*2 +: 2];
        e.gnt = idx;
        e.err = (s == AES_SZ_RSVD) || eng_mute;
        e.data = e.err ? 128'd0 : eng_fn(req_key[idx*256 +: 256], req_data[idx*128 +: 128], s, req_dec[idx]);
        sb.push_back(e);
      end
      if (|(rsp_valid & rsp_ready)) begin
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rsp_who", rsp_valid, N'(1) << e.gnt);
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_err", rsp_err, e.err);
          chk("op_cnt", op_cnt, exp_ops);
          exp_ops = (exp_ops + 1) & 16'hffff;
          exp_ptr = (e.gnt + 1) % N;
        end
        n_rsp++;
        rsp_seen = 0;
      end
    end
  end

  task automatic wait_hs(int r);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = req_valid[r] && req_ready[r];
    end
    chk("hs_wait", ok, 1);
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
  endtask

  task automatic load_op(int r, logic [255:0] k, logic [127:0] d, logic [1:0] s, logic dc);
    req_key[r*256 +: 256] = k;
    req_data[r*128 +: 128] = d;
    req_size[r*2 +: 2] = s;
    req_dec[r] = dc;
  endtask

  task automatic send(int r, logic [255:0] k, logic [127:0] d, logic [1:0] s, logic dc);
    @(posedge clk);
    #1 load_op(r, k, d, s, dc);
    req_valid[r] = 1'b1;
    wait_hs(r);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = !busy && sb.size() == 0;
    end
    chk("idle_wait", ok, 1);
  endtask

  task automatic run_both(int ops);
    int target;
    bit ok = 0;
    target = n_rsp + ops;
    @(posedge clk);
    #1 req_valid = '1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk);
      #1 ok = n_rsp >= target;
    end
    req_valid = '0;
    chk("both_done", ok, 1);
    wait_idle();
  endtask

  initial begin
    logic [127:0] hold;
    int n0, seen;
    bit ok;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_misc", {rsp_err, eng_load, busy, eng_dec, eng_size, op_cnt}, 0);
    chk("rst_eng_key", eng_key, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single request against the known AES-128 vector
    eng_lat = 10;
    send(0, K0, PT, AES_SZ_128, 1'b0);
    wait_idle();
    chk("load_lat", t_load - t_hs, 1);
    chk("rsp_lat", t_rsp - t_hs, 13);
    chk("load_pulses", n_load, 1);
    chk("op_cnt_1", op_cnt, 1);

    // reserved size skips the engine
    n0 = n_load;
    send(1, {128'h0, 128'hfeedface}, 128'h1234, AES_SZ_RSVD, 1'b0);
    wait_idle();
    chk("rsvd_noload", n_load, n0);
    chk("rsvd_lat", t_rsp - t_hs, 1);

    // fairness with both requesters continuously valid
    eng_lat = 3;
    gnt_log.delete();
    load_op(0, {128'h11, 128'h2222}, 128'h3333, AES_SZ_192, 1'b0);
    load_op(1, {128'h44, 128'h5555}, 128'h6666, AES_SZ_256, 1'b1);
    run_both(4);
    chk("fair_n", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("fair_order", gnt_log[i], i % 2);

    // response backpressure
    eng_lat = 4;
    rsp_ready[0] = 1'b0;
    send(0, {128'haa, 128'hbb}, 128'hcc, AES_SZ_256, 1'b1);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = |rsp_valid;
    end
    chk("bp_rsp_seen", ok, 1);
    hold = rsp_data;
    @(posedge clk);
    #1 load_op(1, {128'hdd, 128'hee}, 128'hff, AES_SZ_128, 1'b0);
    req_valid[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 2'b01);
      chk("bp_data", rsp_data, hold);
      chk("bp_ready", req_ready, 0);
    end
    @(posedge clk);
    #1 rsp_ready[0] = 1'b1;
    wait_hs(1);
    wait_idle();

`ifdef AES_SCHED_TIMEOUT_EN
    n0 = op_cnt;
    eng_mute = 1'b1;
    send(0, {128'h1, 128'h2}, 128'h3, AES_SZ_128, 1'b0);
    wait_idle();
    eng_mute = 1'b0;
    chk("tmo_lat", t_rsp - t_load, TMO);
    chk("tmo_ops", op_cnt, n0 + 1);
    send(1, {128'h7, 128'h8}, 128'h9, AES_SZ_192, 1'b1);
    wait_idle();
`endif

    // reset while waiting for the engine to finish
    eng_lat = 5;
    send(0, {128'h21, 128'h22}, 128'h23, AES_SZ_192, 1'b1);
    wait_idle();
    eng_lat = 30;
    send(1, {128'h31, 128'h32}, 128'h33, AES_SZ_128, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    exp_ptr = 0;
    exp_ops = 0;
    rsp_seen = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_rsp_valid", rsp_valid, 0);
    chk("rst2_rsp_data", rsp_data, 0);
    chk("rst2_misc", {rsp_err, eng_load, busy, eng_dec, eng_size, op_cnt}, 0);
    chk("rst2_eng_key", eng_key, 0);
    chk("rst2_eng_data", eng_data, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen += int'(|rsp_valid);
    end
    chk("rst2_no_rsp", seen, 0);
    eng_lat = 3;
    gnt_log.delete();
    load_op(0, {128'h41, 128'h42}, 128'h43, AES_SZ_256, 1'b0);
    load_op(1, {128'h51, 128'h52}, 128'h53, AES_SZ_128, 1'b1);
    run_both(2);
    chk("rst2_n", gnt_log.size(), 2);
    for (int i = 0; i < 2 && i < gnt_log.size(); i++) chk("rst2_order", gnt_log[i], i);
    chk("rst2_ops", op_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion within 20000 cycles");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/aes_sched.md
# aes_sched

Round-robin scheduler that shares one AES engine (load/busy interface, 256-bit key, 128-bit block) between `NUM_REQ` requesters. Each requester issues one operation per valid/ready handshake; the scheduler latches the operands, drives the engine, and waits for completion under a watchdog. It returns the result on a per-requester valid/ready response channel. It sits between capture/test harness logic and the AES core, with at most one operation outstanding.

## Interface
- `NUM_REQ`, 2: number of requesters. Legal range 2..4.
- `TIMEOUT_CYC`, 1024: watchdog limit, in cycles from the load pulse. Must be ≥ 4.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req_valid_i`  in  NUM_REQ  per-requester request valid.
- `req_ready_o`  out  NUM_REQ  per-requester request ready. At most one bit is set.
- `req_key_i`  in  NUM_REQ*256  keys, requester i at bits [i*256 +: 256].
- `req_data_i`  in  NUM_REQ*128  input blocks.
- `req_size_i`  in  NUM_REQ*2  key size: 00=128, 01=192, 10=256, 11=reserved.
- `req_dec_i`  in  NUM_REQ  1 = decrypt.
- `rsp_valid_o`  out  NUM_REQ  response valid, shown to the granted requester only.
- `rsp_ready_i`  in  NUM_REQ  response ready.
- `rsp_data_o`  out  128  result block, shared by all requesters.
- `rsp_err_o`  out  1  error flag (reserved size or timeout).
- `eng_load_o`  out  1  one-cycle start pulse to the engine.
- `eng_key_o`, `eng_data_o`, `eng_size_o`, `eng_dec_o`  out  256/128/2/1  engine operands.
- `eng_data_i`  in  128  engine result.
- `eng_busy_i`  in  1  engine busy.
- `busy_o`  out  1  high whenever the state is not IDLE.
- `op_cnt_o`  out  16  completed operations counter, including errored ones.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE → ISSUE (arbitration):
  - Candidate = first i with `req_valid_i[i]` set, searching `ptr, ptr+1, …` modulo NUM_REQ.
  - `req_ready_o[cand]` is asserted combinationally in IDLE only.
  - On handshake: latch gnt, key, data, size, dec.
- Reserved size: if the latched size is 11, skip the engine and go IDLE → RESP directly, with `rsp_err_o`=1 and `rsp_data_o`=0.
- ISSUE: `eng_load_o`=1 for exactly one cycle, then → WAIT_BUSY.
- Operand outputs: `eng_*_o` come from the latched registers and stay stable from ISSUE through RESP.
- WAIT_BUSY: when `eng_busy_i`=1, → WAIT_DONE.
- WAIT_DONE: when `eng_busy_i`=0, latch `eng_data_i` into `rsp_data_o`, set `rsp_err_o`=0, → RESP.
- RESP:
  - `rsp_valid_o[gnt]`=1, held until `rsp_ready_i[gnt]`=1.
  - On that handshake: `ptr` ← gnt+1 (wraps at NUM_REQ), `op_cnt_o` increments (wraps at 0xFFFF→0), → IDLE.
- Requests are not taken in RESP. A new request can be accepted at the earliest the cycle after the response handshake.
- `rsp_ready_i` on non-granted bits is ignored. `req_valid_i` may drop before handshake without effect.

## Timing
- Reset values: state IDLE, `ptr`=0, all `req_ready_o`/`rsp_valid_o`=0, `rsp_data_o`=0, `rsp_err_o`=0, `eng_load_o`=0, `eng_*_o`=0, `busy_o`=0, `op_cnt_o`=0.
- Request handshake at cycle T: `eng_load_o` at T+1. An engine raising busy at T+2 and dropping it at T+2+L gives `rsp_valid_o` at T+3+L.
- `eng_busy_i` already high in ISSUE is ignored. WAIT_BUSY samples from the cycle after the load pulse.
- Reserved size: handshake at T → `rsp_valid_o` at T+1.
- Reset asserted mid-operation: every register returns to its reset value on the next edge and the in-flight operation is dropped. Any response not yet handshaken is lost.
- All outputs are registered, except `req_ready_o`, which is combinational from `req_valid_i`, state and `ptr`.

## Configuration
- `AES_SCHED_TIMEOUT_EN` defined:
  - A 16-bit counter clears on ISSUE and increments in WAIT_BUSY/WAIT_DONE.
  - On reaching `TIMEOUT_CYC`: → RESP with `rsp_err_o`=1, `rsp_data_o`=0.
  - The engine is not reset; the next ISSUE proceeds normally.
- Not defined: no counter; the scheduler waits indefinitely in WAIT_BUSY/WAIT_DONE.

## Structure
- `aes_sched_pkg`:
  - State enum.
  - `AES_KEY_W`=256, `AES_BLK_W`=128.
  - Size codes `AES_SZ_128/192/256/RSVD`.
- Sub-module `aes_rr_pick`: combinational rotate-priority picker (valid vector + ptr → found flag + index), instantiated once.

## Test plan
- Single request:
  - Stimulus: requester 0 sends key 000102…0f (upper 128 bits zero), size 00, data 00112233445566778899aabbccddeeff, engine model busy for 10 cycles.
  - Required response: `rsp_data_o`=69c4e0d86a7b0430d8cdb78070b4c55a, err=0, `op_cnt_o`=1.
- Fairness: both requesters hold valid continuously for 4 operations → grant order 0,1,0,1.
- Reserved size: requester 1 sends size 11 → `eng_load_o` never pulses, `rsp_valid_o[1]` the cycle after handshake, err=1, data=0.
- Response backpressure: hold `rsp_ready_i`=0 for 20 cycles → `rsp_valid_o` and `rsp_data_o` stable, `req_ready_o`=0 throughout.
- Timeout (`AES_SCHED_TIMEOUT_EN`, `TIMEOUT_CYC`=16): engine never raises busy → err=1 response 16 cycles after the load pulse, `op_cnt_o` increments.
- Reset during WAIT_DONE: `rst_n`=0 for one cycle → all outputs at reset values next cycle, no `rsp_valid_o` for the dropped operation, `ptr`=0.
